// File: rtl/program_loader.sv
// UART program loader: receives 8N1 bytes, packs them little-endian
// into words and strobes each word out with its byte address.
//
// Ports:
//   CLK   - clock, rising edge
//   RST_X - async active-low reset
//   RXD   - UART serial input (idle high, already synchronized)
//   ADDR  - byte address of the word on DATA
//   DATA  - assembled little-endian word
//   WE    - one-cycle strobe qualifying ADDR/DATA
//   DONE  - sticky, image fully received
module program_loader #(
  parameter int CLKS_PER_BIT = 200,
  parameter int LOAD_BYTES   = 16384
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        RXD,
  output logic [31:0] ADDR,
  output logic [31:0] DATA,
  output logic        WE,
  output logic        DONE
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] FULL_M1 =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] LAST_ADDR =
    32'(LOAD_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        byte_ok;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = done_q;
    byte_ok = 1'b0;

    // Address advances as the strobe ends; the last
    // word's strobe end is also when loading is done.
    if (we_q) begin
      addr_d = addr_q + 32'd4;
      if (addr_q == LAST_ADDR) begin
        done_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (!done_q && !RXD) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // High at mid-start means a glitch.
          state_d = RXD ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {RXD, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          byte_ok = RXD && !done_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_ok) begin
      bcnt_d = bcnt_q + 2'd1;
      unique case (1'b1)
        (bcnt_q == 2'd0): word_d[7:0]   = shift_q;
        (bcnt_q == 2'd1): word_d[15:8]  = shift_q;
        (bcnt_q == 2'd2): word_d[23:16] = shift_q;
        (bcnt_q == 2'd3): begin
          data_d = {shift_q, word_q};
          we_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ADDR = addr_q;
  assign DATA = data_q;
  assign WE   = we_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table-driven word loads plus
// hand-written glitch, framing, reset and back-to-back sequences.
module tb_program_loader;

  localparam int CPB = 8;
  localparam int LB  = 8;

  logic        CLK;
  logic        RST_X;
  logic        RXD;
  logic [31:0] ADDR;
  logic [31:0] DATA;
  logic        WE;
  logic        DONE;

  int checks;
  int failures;

  int          we_cnt;
  logic [31:0] we_addr;
  logic [31:0] we_data;
  logic        we_done_in;
  logic        done_after;
  logic        we_prev;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_done;
  } vec_t;

  vec_t vt [2];

  program_loader #(
    .CLKS_PER_BIT(CPB),
    .LOAD_BYTES  (LB)
  ) dut (
    .CLK  (CLK),
    .RST_X(RST_X),
    .RXD  (RXD),
    .ADDR (ADDR),
    .DATA (DATA),
    .WE   (WE),
    .DONE (DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Record each strobe and DONE one cycle later.
  always @(negedge CLK) begin
    if (WE) begin
      we_cnt     = we_cnt + 1;
      we_addr    = ADDR;
      we_data    = DATA;
      we_done_in = DONE;
    end
    if (we_prev) done_after = DONE;
    we_prev = WE;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stopb,
                           input int gap);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stopb;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_word(input logic [7:0] b0,
                           input logic [7:0] b1,
                           input logic [7:0] b2,
                           input logic [7:0] b3,
                           input int gap);
    send_byte(b0, 1'b1, gap);
    send_byte(b1, 1'b1, gap);
    send_byte(b2, 1'b1, gap);
    send_byte(b3, 1'b1, gap);
    repeat (4) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RXD   = 1'b1;
    RST_X = 1'b0;
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  int base;

  initial begin
    checks     = 0;
    failures   = 0;
    we_cnt     = 0;
    we_addr    = '0;
    we_data    = '0;
    we_done_in = 1'b0;
    done_after = 1'b0;
    we_prev    = 1'b0;
    RXD        = 1'b1;
    RST_X      = 1'b1;

    vt[0] = '{8'h13, 8'h00, 8'h00, 8'h00,
              32'h0, 32'h00000013, 1'b0};
    vt[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE,
              32'h4, 32'hDEADBEEF, 1'b1};

    // Asynchronous reset before any clock edge.
    #2 RST_X = 1'b0;
    #1;
    chk("rst_addr", ADDR, 32'h0);
    chk("rst_data", DATA, 32'h0);
    chk("rst_we", {31'b0, WE}, 32'h0);
    chk("rst_done", {31'b0, DONE}, 32'h0);
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);

    for (int v = 0; v < 2; v++) begin
      base = we_cnt;
      send_word(vt[v].b0, vt[v].b1, vt[v].b2,
                vt[v].b3, 3);
      chk("tbl_we_cnt", 32'(we_cnt - base), 32'd1);
      chk("tbl_addr", we_addr, vt[v].exp_addr);
      chk("tbl_data", we_data, vt[v].exp_data);
      chk("tbl_done_in_we", {31'b0, we_done_in}, 32'h0);
      chk("tbl_done_after", {31'b0, done_after},
          {31'b0, vt[v].exp_done});
    end

    // Further frames ignored once DONE.
    base = we_cnt;
    send_word(8'h55, 8'h66, 8'h77, 8'h88, 2);
    chk("done_no_we", 32'(we_cnt - base), 32'd0);
    chk("done_addr", ADDR, 32'h8);
    chk("done_data", DATA, 32'hDEADBEEF);
    chk("done_sticky", {31'b0, DONE}, 32'h1);

    // Two-cycle low glitch on idle line.
    do_reset();
    base = we_cnt;
    RXD = 1'b0;
    repeat (2) @(negedge CLK);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
    chk("glitch_no_we", 32'(we_cnt - base), 32'd0);
    send_word(8'h11, 8'h22, 8'h33, 8'h44, 2);
    chk("glitch_we_cnt", 32'(we_cnt - base), 32'd1);
    chk("glitch_addr", we_addr, 32'h0);
    chk("glitch_data", we_data, 32'h44332211);

    // Framing error after the second byte.
    base = we_cnt;
    send_byte(8'hA1, 1'b1, 2);
    send_byte(8'hB2, 1'b1, 2);
    send_byte(8'hC3, 1'b0, 4);
    send_byte(8'hC4, 1'b1, 2);
    chk("frm_partial", 32'(we_cnt - base), 32'd0);
    send_byte(8'hD5, 1'b1, 2);
    repeat (4) @(negedge CLK);
    chk("frm_we_cnt", 32'(we_cnt - base), 32'd1);
    chk("frm_addr", we_addr, 32'h4);
    chk("frm_data", we_data, 32'hD5C4B2A1);

    // Reset in the middle of a word.
    do_reset();
    send_word(8'hAA, 8'hBB, 8'hCC, 8'hDD, 2);
    send_byte(8'h9A, 1'b1, 2);
    send_byte(8'h9B, 1'b1, 2);
    #2 RST_X = 1'b0;
    #1;
    chk("mid_rst_addr", ADDR, 32'h0);
    chk("mid_rst_data", DATA, 32'h0);
    chk("mid_rst_we", {31'b0, WE}, 32'h0);
    chk("mid_rst_done", {31'b0, DONE}, 32'h0);
    @(negedge CLK);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);
    base = we_cnt;
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 2);
    chk("post_rst_we_cnt", 32'(we_cnt - base), 32'd1);
    chk("post_rst_addr", we_addr, 32'h0);
    chk("post_rst_data", we_data, 32'h04030201);

    // Back-to-back frames, no idle gap.
    do_reset();
    base = we_cnt;
    send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
    chk("b2b_we_cnt", 32'(we_cnt - base), 32'd1);
    chk("b2b_addr", we_addr, 32'h0);
    chk("b2b_data", we_data, 32'hFFFFFFFF);
    chk("b2b_addr_next", ADDR, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
